// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-way grant logic; MEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    always_comb begin
        grant_valid = |req;
        grant       = PORT_CPU;
`ifdef MEM_ARB_CPU_PRIORITY_EN
        // With no request the grant is a don't-care, so it simply follows last_grant.
        if (req[PORT_CPU]) begin
            grant = PORT_CPU;
        end else if (req[PORT_DBG]) begin
            grant = PORT_DBG;
        end else begin
            grant = last_grant;
        end
`else
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            grant = ~last_grant;
        end else if (req[PORT_DBG]) begin
            grant = PORT_DBG;
        end else begin
            grant = PORT_CPU;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DBG arbiter for a single-ported memory; MEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be within 1..7");
    end

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]     dbg_rdata_q, dbg_rdata_d;

    logic              grant_valid;
    logic              grant;

    rr_arb2 u_arb (
        .req         ({dbg_req, cpu_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (grant == PORT_DBG) begin
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // Count value 1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    if (owner_q == PORT_DBG) begin
                        dbg_rdata_d = mem_rdata;
                        dbg_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= PORT_CPU;
            last_grant_q <= PORT_DBG;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign owner     = owner_q;

endmodule
